need_monitor: RTL and testbench

- Parametrised successor to the pet status generator.
- Watches NCH need levels of LW bits each. Produces a per-channel alert vector with hysteresis and a priority "most urgent need" index.
- Runs a life-state FSM (OK/WARN/CRIT/DEAD) with a tick-timed death countdown and an explicit revive.
- Sits between the need-level counters and the display/sound controllers.

---
 rtl/need_monitor_if.sv | 39 +++
 rtl/need_monitor.sv | 152 +++++++++++++++
 tb/tb_need_monitor.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/need_monitor_if.sv
// need_monitor_if: groups the need-level inputs and the status outputs of
// need_monitor.
//   master : level-counter / display side (drives tick, levels, revive, mask)
//   slave  : the monitor itself
// With NEED_MONITOR_MASK_EN defined, an NCH-bit mask signal is added.
interface need_monitor_if #(
  parameter int NCH = 6,
  parameter int LW  = 5,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
);
  logic              tick;
  logic [NCH*LW-1:0] levels;
  logic              revive;
`ifdef NEED_MONITOR_MASK_EN
  logic [NCH-1:0]    mask;
`endif
  logic [NCH-1:0]    alert;
  logic              top_valid;
  logic [IW-1:0]     top_idx;
  logic [1:0]        state;
  logic              dead;
  logic              alert_chg;

  modport master (
    output tick, levels, revive,
`ifdef NEED_MONITOR_MASK_EN
    output mask,
`endif
    input  alert, top_valid, top_idx, state, dead, alert_chg
  );

  modport slave (
    input  tick, levels, revive,
`ifdef NEED_MONITOR_MASK_EN
    input  mask,
`endif
    output alert, top_valid, top_idx, state, dead, alert_chg
  );
endinterface

// File: rtl/need_monitor.sv
// need_monitor: per-channel need alerts with hysteresis, a "most urgent"
// channel index, and an OK/WARN/CRIT/DEAD life FSM with a tick-timed death
// countdown and explicit revive. All outputs registered (1-cycle latency).
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : need_monitor_if.slave (tick, levels, revive, [mask] in;
//                alert, top_valid, top_idx, state, dead, alert_chg out)
// Optional: NEED_MONITOR_MASK_EN adds bus.mask; masked channels never alert,
// never win priority and never count as critical (ignored in DEAD).

// Per-channel hysteresis and critical detect.
module need_lane #(
  parameter int LW       = 5,
  parameter int SET_TH   = 12,
  parameter int CLR_TH   = 9,
  parameter int CRIT_LVL = 31
) (
  input  logic [LW-1:0] lvl,
  input  logic          msk,
  input  logic          cur,
  output logic          hyst,
  output logic          crit
);
  always_comb begin
    hyst = cur;
    if (msk)                       hyst = 1'b0;
    else if (32'(lvl) >= SET_TH)   hyst = 1'b1;
    else if (32'(lvl) <= CLR_TH)   hyst = 1'b0;
    crit = !msk && (32'(lvl) >= CRIT_LVL);
  end
endmodule

module need_monitor #(
  parameter int NCH         = 6,
  parameter int LW          = 5,
  parameter int SET_TH      = 12,
  parameter int CLR_TH      = 9,
  parameter int CRIT_LVL    = 31,
  parameter int DEATH_TICKS = 8,
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic         clk,
  input  logic         reset,
  need_monitor_if.slave bus
);
  localparam int CW = $clog2(DEATH_TICKS + 1);

  typedef enum logic [1:0] {S_OK = 2'd0, S_WARN = 2'd1, S_CRIT = 2'd2, S_DEAD = 2'd3} state_t;

  state_t                  state_q, state_n;
  logic [CW-1:0]           cnt_q, cnt_n;
  logic [NCH-1:0]          alert_q, alert_n;
  logic                    tv_q, tv_n;
  logic [IW-1:0]           ti_q, ti_n;
  logic                    chg_q, dead_q;
  logic [NCH-1:0][LW-1:0]  lvls;
  logic [NCH-1:0]          msk, hyst, crit;
  logic                    crit_any;
  logic [LW-1:0]           best;

  assign lvls = bus.levels;
`ifdef NEED_MONITOR_MASK_EN
  assign msk = bus.mask;
`else
  assign msk = '0;
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    need_lane #(.LW(LW), .SET_TH(SET_TH), .CLR_TH(CLR_TH), .CRIT_LVL(CRIT_LVL)) u_lane (
      .lvl (lvls[i]),
      .msk (msk[i]),
      .cur (alert_q[i]),
      .hyst(hyst[i]),
      .crit(crit[i])
    );
  end

  assign crit_any = |crit;

  // Life FSM + death counter. Counter only advances on tick while critical;
  // a critical drop always wins over a coincident tick.
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    alert_n = hyst;
    if (state_q == S_DEAD) begin
      alert_n = '1;
      if (bus.revive) begin
        state_n = S_OK;
        alert_n = '0;
        cnt_n   = '0;
      end
    end else if (crit_any) begin
      state_n = S_CRIT;
      if (bus.tick) begin
        if (cnt_q == CW'(DEATH_TICKS - 1)) begin
          state_n = S_DEAD;
          alert_n = '1;
          cnt_n   = CW'(DEATH_TICKS);
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
    end else begin
      cnt_n   = '0;
      state_n = (|hyst) ? S_WARN : S_OK;
    end
  end

  // Most urgent alerted channel; strict '>' keeps the lowest index on ties.
  always_comb begin
    tv_n = 1'b0;
    ti_n = '0;
    best = '0;
    if (state_n != S_DEAD) begin
      for (int i = 0; i < NCH; i++) begin
        if (alert_n[i] && (!tv_n || lvls[i] > best)) begin
          tv_n = 1'b1;
          ti_n = IW'(i);
          best = lvls[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_OK;
      cnt_q   <= '0;
      alert_q <= '0;
      tv_q    <= 1'b0;
      ti_q    <= '0;
      chg_q   <= 1'b0;
      dead_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      alert_q <= alert_n;
      tv_q    <= tv_n;
      ti_q    <= ti_n;
      chg_q   <= (alert_n != alert_q);
      dead_q  <= (state_n == S_DEAD);
    end
  end

  assign bus.alert     = alert_q;
  assign bus.top_valid = tv_q;
  assign bus.top_idx   = ti_q;
  assign bus.state     = state_q;
  assign bus.dead      = dead_q;
  assign bus.alert_chg = chg_q;
endmodule

// File: tb/tb_need_monitor.sv
// Randomized + directed bench for need_monitor against a behavioural model.
module tb_need_monitor;
  localparam int NCH = 6, LW = 5, SET = 12, CLR = 9, CRIT = 31, DT = 8;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  need_monitor_if #(.NCH(NCH), .LW(LW)) bus();
  need_monitor #(.NCH(NCH), .LW(LW), .SET_TH(SET), .CLR_TH(CLR),
                 .CRIT_LVL(CRIT), .DEATH_TICKS(DT)) dut (
    .clk(clk), .reset(rst), .bus(bus));

  int n_chk = 0, n_err = 0;
  int lv[NCH];
  bit tk, rv;
  bit [NCH-1:0] mk;

  // model state
  bit [NCH-1:0] m_alert;
  int m_state, m_cnt, m_ti;
  bit m_chg, m_tv;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [NCH-1:0] old, na;
    bit crit;
    int best;
    old = m_alert;
    if (rst) begin
      m_alert = '0; m_state = 0; m_cnt = 0; m_chg = 0; m_tv = 0; m_ti = 0;
      return;
    end
    if (m_state == 3) begin
      if (rv) begin m_state = 0; m_alert = '0; m_cnt = 0; end
    end else begin
      crit = 0;
      for (int c = 0; c < NCH; c++) begin
        if (mk[c]) na[c] = 0;
        else begin
          if (lv[c] >= SET) na[c] = 1;
          else if (lv[c] <= CLR) na[c] = 0;
          else na[c] = old[c];
          if (lv[c] >= CRIT) crit = 1;
        end
      end
      if (crit) begin
        if (tk) m_cnt++;
        if (m_cnt >= DT) begin m_state = 3; na = '1; end
        else m_state = 2;
      end else begin
        m_cnt = 0;
        m_state = (na != 0) ? 1 : 0;
      end
      m_alert = na;
    end
    m_chg = (m_alert != old);
    m_tv = 0; m_ti = 0; best = -1;
    if (m_state != 3)
      for (int c = 0; c < NCH; c++)
        if (m_alert[c] && lv[c] > best) begin best = lv[c]; m_ti = c; m_tv = 1; end
  endtask

  // Apply current stimulus variables, clock once, then compare everything.
  task automatic step();
    for (int c = 0; c < NCH; c++) bus.levels[c*LW +: LW] = LW'(lv[c]);
    bus.tick = tk; bus.revive = rv;
`ifdef NEED_MONITOR_MASK_EN
    bus.mask = mk;
`endif
    @(posedge clk);
    model_step();
    #1;
    chk("alert", int'(bus.alert), int'(m_alert));
    chk("top_valid", int'(bus.top_valid), int'(m_tv));
    chk("top_idx", int'(bus.top_idx), m_ti);
    chk("state", int'(bus.state), m_state);
    chk("dead", int'(bus.dead), int'(m_state == 3));
    chk("alert_chg", int'(bus.alert_chg), int'(m_chg));
    @(negedge clk);
    tk = 0; rv = 0;
  endtask

  task automatic set_all(input int v);
    for (int c = 0; c < NCH; c++) lv[c] = v;
  endtask

  initial begin
    tk = 0; rv = 0; mk = '0; set_all(5);
    @(negedge clk);
    rst = 1; step(); step();
    chk("rst_state", int'(bus.state), 0);
    chk("rst_alert", int'(bus.alert), 0);
    rst = 0;
    for (int i = 0; i < 4; i++) step();
    chk("idle_chg", int'(bus.alert_chg), 0);
    // hunger hysteresis
    lv[0] = 12; step();
    chk("hunger_set", int'(bus.alert), 1);
    chk("hunger_pulse", int'(bus.alert_chg), 1);
    step();
    lv[0] = 10; step(); step();
    chk("hunger_hold", int'(bus.alert), 1);
    lv[0] = 9; step();
    chk("hunger_clr", int'(bus.alert), 0);
    chk("ok_again", int'(bus.state), 0);
    // priority and tie
    lv[0] = 13; lv[3] = 14; step();
    chk("pri_alert", int'(bus.alert), 6'b001001);
    chk("pri_idx", int'(bus.top_idx), 3);
    lv[3] = 13; step();
    chk("tie_idx", int'(bus.top_idx), 0);
    // death by ticks
    set_all(5); step(); step();
    lv[2] = 31;
    for (int i = 0; i < 40; i++) begin tk = (i % 4 == 0); step(); end
    chk("tp_dead", int'(bus.dead), 1);
    chk("tp_dead_alert", int'(bus.alert), 6'b111111);
    lv[2] = 20;
    for (int i = 0; i < 5; i++) step();
    chk("stay_dead", int'(bus.state), 3);
    rv = 1; step();
    chk("revive_state", int'(bus.state), 0);
    chk("revive_pulse", int'(bus.alert_chg), 1);
    step();
    // 7 ticks, then drop coincident with tick, then fresh countdown
    set_all(5); step();
    lv[2] = 31;
    for (int i = 0; i < 14; i++) begin tk = (i % 2 == 0); step(); end
    lv[2] = 20; tk = 1; step();
    chk("drop_wins", int'(bus.state), 1);
    lv[2] = 31;
    for (int i = 0; i < 14; i++) begin tk = (i % 2 == 0); step(); end
    chk("no_early_death", int'(bus.dead), 0);
    tk = 1; step();
    chk("fresh_death", int'(bus.dead), 1);
    rv = 1; step();
`ifdef NEED_MONITOR_MASK_EN
    set_all(5); lv[2] = 31; mk = 6'b000100;
    for (int i = 0; i < 20; i++) begin tk = 1; step(); end
    chk("mask_alert", int'(bus.alert), 0);
    chk("mask_nodead", int'(bus.state), 0);
    mk = '0; step();
    chk("unmask_crit", int'(bus.state), 2);
    rst = 1; step(); rst = 0;
`endif
    // randomized phases
    for (int ph = 0; ph < 60; ph++) begin
      int mode, cc;
      mode = $urandom_range(0, 2);
      cc = $urandom_range(0, NCH - 1);
      for (int i = 0; i < 50; i++) begin
        for (int c = 0; c < NCH; c++) begin
          if (mode == 0) lv[c] = $urandom_range(0, 15);
          else if (mode == 1) begin
            if ($urandom_range(0, 3) == 0) lv[c] = $urandom_range(8, 14);
          end else lv[c] = $urandom_range(0, 20);
        end
        if (mode == 2 && $urandom_range(0, 19) != 0) lv[cc] = 31;
        if ($urandom_range(0, 40) == 0) lv[$urandom_range(0, NCH - 1)] = 31;
        tk = ($urandom_range(0, 2) == 0);
        rv = ($urandom_range(0, 15) == 0);
`ifdef NEED_MONITOR_MASK_EN
        if ($urandom_range(0, 9) == 0) mk = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
`endif
        rst = ($urandom_range(0, 299) == 0);
        step();
        rst = 0;
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
